// File: rtl/stim_pattern_gen.sv
// -----------------------------------------------------------------------------
// stim_pattern_gen
//   Stimulus generator for ISCAS combinational netlists. It issues a programmed
//   number of WIDTH-bit vectors through a valid/ready handshake. The vector
//   patterns are hold, staggered toggle, LFSR and walking-one. After each
//   accepted vector it can insert a programmable number of idle cycles.
//
//   Optional feature: define STIM_SIG_EN to build a 32-bit MISR that compacts
//   the DUT response on every acceptance. Without the macro, resp_i is ignored
//   and signature_o is tied to zero.
//
// Ports
//   clk_i        rising-edge clock
//   reset_ni     synchronous active-low reset
//   mode_i       0 HOLD, 1 STAGGER, 2 LFSR, 3 WALK1 (sampled on start)
//   num_vec_i    number of vectors to issue, 0 = run until stop (sampled on start)
//   gap_i        idle cycles after each accepted vector (sampled on start)
//   start_i      one-cycle start pulse, honoured only when idle
//   stop_i       abort, honoured while running or in a gap
//   vec_o        current stimulus vector
//   vec_valid_o  vec_o holds a vector that has not been accepted yet
//   vec_ready_i  consumer accepts vec_o when vec_valid_o & vec_ready_i
//   vec_idx_o    0-based index of the vector on vec_o
//   busy_o       high while running or in a gap
//   done_o       one-cycle pulse after the last vector is accepted
//   resp_i       DUT response (MISR input, STIM_SIG_EN only)
//   signature_o  MISR signature
// -----------------------------------------------------------------------------
module stim_pattern_gen #(
   parameter int unsigned WIDTH = 41,
   parameter int unsigned CNT_W = 16,
   parameter logic [31:0] SEED  = 32'h0000_0001
) (
   input  logic             clk_i,
   input  logic             reset_ni,
   input  logic [1:0]       mode_i,
   input  logic [CNT_W-1:0] num_vec_i,
   input  logic [CNT_W-1:0] gap_i,
   input  logic             start_i,
   input  logic             stop_i,
   output logic [WIDTH-1:0] vec_o,
   output logic             vec_valid_o,
   input  logic             vec_ready_i,
   output logic [CNT_W-1:0] vec_idx_o,
   output logic             busy_o,
   output logic             done_o,
   input  logic [WIDTH-1:0] resp_i,
   output logic [31:0]      signature_o
);

   localparam logic [31:0] MASK     = 32'h8020_0003;
   localparam logic [31:0] SEED_EFF = (SEED == 32'h0) ? 32'h1 : SEED;
   localparam int unsigned PW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_GAP, S_DONE} state_t;

   state_t           state_q, state_d;
   logic [1:0]       mode_q, mode_d;
   logic [CNT_W-1:0] num_q, num_d, gap_q, gap_d, gcnt_q, gcnt_d, idx_q, idx_d;
   logic [PW-1:0]    pos_q, pos_d;
   logic [WIDTH-1:0] vec_q, vec_d;
   logic [31:0]      lfsr_q, lfsr_d, lfsr_nxt;

   logic             start_ok, acc, last;
   logic [WIDTH-1:0] lfsr_vec, seed_vec, walk_vec, stag_vec, next_vec, vec0;

   assign start_ok = (state_q == S_IDLE) && start_i;
   assign acc      = (state_q == S_RUN) && vec_ready_i;
   assign last     = (num_q != '0) && (idx_q == num_q - CNT_W'(1));
   // Galois step, left-shifting so a seed of 1 steps to 2.
   assign lfsr_nxt = {lfsr_q[30:0], 1'b0} ^ (lfsr_q[31] ? MASK : 32'h0);

   // Candidate patterns. The walk is a rotate, and the stagger flips the bit
   // pointed to by pos_q, which tracks the index mod WIDTH without a divider.
   always_comb begin : patterns
      lfsr_vec = '0;
      seed_vec = '0;
      walk_vec = '0;
      for (int i = 0; i < int'(WIDTH); i++) begin
         lfsr_vec[i] = lfsr_nxt[i % 32];
         seed_vec[i] = SEED_EFF[i % 32];
         walk_vec[i] = vec_q[(i + int'(WIDTH) - 1) % int'(WIDTH)];
      end
      stag_vec        = vec_q;
      stag_vec[pos_q] = ~vec_q[pos_q];
      case (mode_q)
         2'd1:    next_vec = stag_vec;
         2'd2:    next_vec = lfsr_vec;
         2'd3:    next_vec = walk_vec;
         default: next_vec = '0;
      endcase
      case (mode_i)
         2'd2:    vec0 = seed_vec;
         2'd3:    vec0 = WIDTH'(1);
         default: vec0 = '0;
      endcase
   end

   always_comb begin : datapath
      mode_d = mode_q;
      num_d  = num_q;
      gap_d  = gap_q;
      gcnt_d = gcnt_q;
      idx_d  = idx_q;
      pos_d  = pos_q;
      vec_d  = vec_q;
      lfsr_d = lfsr_q;
      if (start_ok) begin
         mode_d = mode_i;
         num_d  = num_vec_i;
         gap_d  = gap_i;
         idx_d  = '0;
         pos_d  = '0;
         lfsr_d = SEED_EFF;
         vec_d  = vec0;
      end else if (acc) begin
         gcnt_d = gap_q;
         // The last vector stays on the outputs after completion.
         if (!last) begin
            idx_d  = idx_q + CNT_W'(1);
            pos_d  = (pos_q == PW'(WIDTH - 1)) ? '0 : pos_q + PW'(1);
            lfsr_d = lfsr_nxt;
            vec_d  = next_vec;
         end
      end else if (state_q == S_GAP) begin
         gcnt_d = gcnt_q - CNT_W'(1);
      end
   end

   // FSM: state register
   always_ff @(posedge clk_i) begin
      if (!reset_ni) state_q <= S_IDLE;
      else           state_q <= state_d;
   end

   // FSM: next state
   always_comb begin : next_state
      state_d = state_q;
      case (state_q)
         S_IDLE: if (start_i) state_d = S_RUN;
         S_RUN: begin
            if (stop_i)      state_d = S_IDLE;
            else if (acc) begin
               if (last)                state_d = S_DONE;
               else if (gap_q != '0)    state_d = S_GAP;
            end
         end
         S_GAP: begin
            if (stop_i)                     state_d = S_IDLE;
            else if (gcnt_q == CNT_W'(1))   state_d = S_RUN;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // FSM: outputs
   always_comb begin : fsm_out
      vec_valid_o = 1'b0;
      busy_o      = 1'b0;
      done_o      = 1'b0;
      case (state_q)
         S_RUN:   begin vec_valid_o = 1'b1; busy_o = 1'b1; end
         S_GAP:   busy_o = 1'b1;
         S_DONE:  done_o = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!reset_ni) begin
         mode_q <= '0;
         num_q  <= '0;
         gap_q  <= '0;
         gcnt_q <= '0;
         idx_q  <= '0;
         pos_q  <= '0;
         vec_q  <= '0;
         lfsr_q <= SEED_EFF;
      end else begin
         mode_q <= mode_d;
         num_q  <= num_d;
         gap_q  <= gap_d;
         gcnt_q <= gcnt_d;
         idx_q  <= idx_d;
         pos_q  <= pos_d;
         vec_q  <= vec_d;
         lfsr_q <= lfsr_d;
      end
   end

   assign vec_o     = vec_q;
   assign vec_idx_o = idx_q;

`ifdef STIM_SIG_EN
   logic [31:0] sig_q, sig_d, fold;

   // Fold the response into 32 bits by XOR of zero-padded 32-bit slices.
   always_comb begin : misr
      fold = '0;
      for (int i = 0; i < int'(WIDTH); i++) fold[i % 32] = fold[i % 32] ^ resp_i[i];
      sig_d = sig_q;
      if (start_ok)  sig_d = '0;
      else if (acc)  sig_d = {sig_q[30:0], 1'b0} ^ (sig_q[31] ? MASK : 32'h0) ^ fold;
   end

   always_ff @(posedge clk_i) begin
      if (!reset_ni) sig_q <= '0;
      else           sig_q <= sig_d;
   end

   assign signature_o = sig_q;
`else
   logic unused_resp;
   assign unused_resp = ^resp_i;
   assign signature_o = '0;
`endif

endmodule

// File: tb/tb_stim_pattern_gen.sv
module tb_stim_pattern_gen;
   localparam int WA = 8,  CA = 4;
   localparam int WB = 41, CB = 16;
   localparam logic [31:0] MASK = 32'h8020_0003;
   localparam int P_IDLE = 0, P_RUN = 1, P_GAP = 2, P_DONE = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Instance A: WIDTH=8, CNT_W=4 (stagger table, index wrap)
   logic          a_rst_n, a_start, a_stop, a_ready, a_valid, a_busy, a_done;
   logic [1:0]    a_mode;
   logic [CA-1:0] a_num, a_gap, a_idx;
   logic [WA-1:0] a_vec, a_resp;
   logic [31:0]   a_sig;

   stim_pattern_gen #(.WIDTH(WA), .CNT_W(CA), .SEED(32'h1)) u_a (
      .clk_i(clk), .reset_ni(a_rst_n), .mode_i(a_mode), .num_vec_i(a_num), .gap_i(a_gap),
      .start_i(a_start), .stop_i(a_stop), .vec_o(a_vec), .vec_valid_o(a_valid),
      .vec_ready_i(a_ready), .vec_idx_o(a_idx), .busy_o(a_busy), .done_o(a_done),
      .resp_i(a_resp), .signature_o(a_sig));

   // Instance B: WIDTH=41, CNT_W=16, checked against the reference model
   logic          b_rst_n, b_start, b_stop, b_ready, b_valid, b_busy, b_done;
   logic [1:0]    b_mode;
   logic [CB-1:0] b_num, b_gap, b_idx;
   logic [WB-1:0] b_vec, b_resp;
   logic [31:0]   b_sig;

   stim_pattern_gen #(.WIDTH(WB), .CNT_W(CB), .SEED(32'h1)) u_b (
      .clk_i(clk), .reset_ni(b_rst_n), .mode_i(b_mode), .num_vec_i(b_num), .gap_i(b_gap),
      .start_i(b_start), .stop_i(b_stop), .vec_o(b_vec), .vec_valid_o(b_valid),
      .vec_ready_i(b_ready), .vec_idx_o(b_idx), .busy_o(b_busy), .done_o(b_done),
      .resp_i(b_resp), .signature_o(b_sig));

   int n_run = 0, n_fail = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_run++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model for instance B ----------------
   int          ph, k, mn, mg, gl;
   logic [1:0]  mm;
   logic [31:0] msig;

   function automatic logic [31:0] lfsr_steps(input int n);
      logic [31:0] s;
      s = 32'h1;
      for (int j = 0; j < n; j++) s = {s[30:0], 1'b0} ^ (s[31] ? MASK : 32'h0);
      return s;
   endfunction

   function automatic logic [WB-1:0] rep32(input logic [31:0] x);
      logic [WB-1:0] v;
      for (int i = 0; i < WB; i++) v[i] = x[i % 32];
      return v;
   endfunction

   // Vector k computed directly from its index.
   function automatic logic [WB-1:0] exp_vec(input logic [1:0] md, input int kk);
      logic [WB-1:0] v;
      v = '0;
      case (md)
         2'd1: for (int i = 0; i < WB; i++)
                  v[i] = (((kk / WB) + ((i < kk % WB) ? 1 : 0)) % 2) == 1;
         2'd2: v = rep32(lfsr_steps(kk));
         2'd3: v[kk % WB] = 1'b1;
         default: ;
      endcase
      return v;
   endfunction

   function automatic logic [31:0] misr(input logic [31:0] s, input logic [WB-1:0] r);
      logic [31:0] f;
      f = '0;
      for (int i = 0; i < WB; i++) f[i % 32] = f[i % 32] ^ r[i];
      return {s[30:0], 1'b0} ^ (s[31] ? MASK : 32'h0) ^ f;
   endfunction

   task automatic model_step(input logic rn, st, sp, rd, input logic [WB-1:0] rs);
      bit lst;
      if (!rn) begin ph = P_IDLE; k = 0; mm = 2'd0; msig = '0; return; end
      case (ph)
         P_IDLE: if (st) begin
            ph = P_RUN; k = 0; msig = '0; mm = b_mode; mn = int'(b_num); mg = int'(b_gap);
         end
         P_RUN: begin
            if (rd) begin
               lst  = (mn != 0) && (k == mn - 1);
               msig = misr(msig, rs);
               if (!lst) k++;
               if (sp)           ph = P_IDLE;
               else if (lst)     ph = P_DONE;
               else if (mg != 0) begin ph = P_GAP; gl = mg; end
            end else if (sp) ph = P_IDLE;
         end
         P_GAP: begin
            if (sp)           ph = P_IDLE;
            else if (gl == 1) ph = P_RUN;
            else              gl--;
         end
         default: ph = P_IDLE;
      endcase
   endtask

   // One clock of instance B: drive at negedge, step model, check at next negedge.
   task automatic cyc(input logic st, sp, rd, input logic rn = 1'b1);
      logic [WB-1:0] rs;
      logic [31:0]   esig;
      rs = WB'({$urandom(), $urandom()});
      b_rst_n = rn; b_start = st; b_stop = sp; b_ready = rd; b_resp = rs;
      model_step(rn, st, sp, rd, rs);
      @(negedge clk);
`ifdef STIM_SIG_EN
      esig = msig;
`else
      esig = 32'h0;
`endif
      chk("b_valid", 64'(b_valid), 64'(ph == P_RUN));
      chk("b_busy",  64'(b_busy),  64'(ph == P_RUN || ph == P_GAP));
      chk("b_done",  64'(b_done),  64'(ph == P_DONE));
      chk("b_vec",   64'(b_vec),   64'(exp_vec(mm, k)));
      chk("b_idx",   64'(b_idx),   64'(CB'(k)));
      chk("b_sig",   64'(b_sig),   64'(esig));
   endtask

   // ---------------- table for instance A ----------------
   typedef struct {
      logic st, rd, sp, v, busy, done;
      logic [WA-1:0] vec;
      logic [CA-1:0] idx;
   } arow_t;
   arow_t tab[6];

   initial begin
      int nv, nd;
      tab[0] = '{st:1'b1, rd:1'b0, sp:1'b0, v:1'b1, busy:1'b1, done:1'b0, vec:8'h00, idx:4'd0};
      tab[1] = '{st:1'b0, rd:1'b1, sp:1'b0, v:1'b1, busy:1'b1, done:1'b0, vec:8'h01, idx:4'd1};
      tab[2] = '{st:1'b0, rd:1'b1, sp:1'b0, v:1'b1, busy:1'b1, done:1'b0, vec:8'h03, idx:4'd2};
      tab[3] = '{st:1'b0, rd:1'b1, sp:1'b0, v:1'b1, busy:1'b1, done:1'b0, vec:8'h07, idx:4'd3};
      tab[4] = '{st:1'b0, rd:1'b1, sp:1'b0, v:1'b0, busy:1'b0, done:1'b1, vec:8'h07, idx:4'd3};
      tab[5] = '{st:1'b0, rd:1'b1, sp:1'b0, v:1'b0, busy:1'b0, done:1'b0, vec:8'h07, idx:4'd3};

      a_rst_n = 1'b0; a_start = 1'b0; a_stop = 1'b0; a_ready = 1'b0;
      a_mode = 2'd0; a_num = '0; a_gap = '0; a_resp = '0;
      b_rst_n = 1'b0; b_start = 1'b0; b_stop = 1'b0; b_ready = 1'b0;
      b_mode = 2'd0; b_num = '0; b_gap = '0; b_resp = '0;
      ph = P_IDLE; k = 0; mm = 2'd0; msig = '0; mn = 0; mg = 0; gl = 0;

      // ---- A: reset state ----
      @(negedge clk); @(negedge clk);
      chk("a_rst_valid", 64'(a_valid), 64'(0));
      chk("a_rst_busy",  64'(a_busy),  64'(0));
      chk("a_rst_done",  64'(a_done),  64'(0));
      chk("a_rst_vec",   64'(a_vec),   64'(0));
      chk("a_rst_idx",   64'(a_idx),   64'(0));
      chk("a_rst_sig",   64'(a_sig),   64'(0));
      a_rst_n = 1'b1;

      // ---- A: stagger, num_vec=4, gap=0 ----
      a_mode = 2'd1; a_num = 4'd4; a_gap = 4'd0;
      for (int r = 0; r < 6; r++) begin
         a_start = tab[r].st; a_ready = tab[r].rd; a_stop = tab[r].sp;
         @(negedge clk);
         chk("a_tab_valid", 64'(a_valid), 64'(tab[r].v));
         chk("a_tab_busy",  64'(a_busy),  64'(tab[r].busy));
         chk("a_tab_done",  64'(a_done),  64'(tab[r].done));
         chk("a_tab_vec",   64'(a_vec),   64'(tab[r].vec));
         chk("a_tab_idx",   64'(a_idx),   64'(tab[r].idx));
      end

      // ---- A: endless walk-one, index wraps 15 -> 0, then stop ----
      a_mode = 2'd3; a_num = 4'd0; a_start = 1'b1; a_ready = 1'b0;
      @(negedge clk);
      chk("a_wrap_idx0", 64'(a_idx), 64'(0));
      chk("a_wrap_vec0", 64'(a_vec), 64'(1));
      a_start = 1'b0; a_ready = 1'b1;
      for (int j = 1; j <= 20; j++) begin
         @(negedge clk);
         chk("a_wrap_idx",  64'(a_idx),   64'(j % 16));
         chk("a_wrap_vec",  64'(a_vec),   64'(1 << (j % 8)));
         chk("a_wrap_done", 64'(a_done),  64'(0));
         chk("a_wrap_val",  64'(a_valid), 64'(1));
      end
      a_stop = 1'b1; a_ready = 1'b0;
      @(negedge clk);
      chk("a_stop_valid", 64'(a_valid), 64'(0));
      chk("a_stop_busy",  64'(a_busy),  64'(0));
      chk("a_stop_done",  64'(a_done),  64'(0));
      a_stop = 1'b0;
      @(negedge clk);
      chk("a_stop_done2", 64'(a_done), 64'(0));

      // ---- B: reset state ----
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0);

      // ---- B: walk-one, 43 vectors, gap 2 ----
      b_mode = 2'd3; b_num = 16'd43; b_gap = 16'd2;
      cyc(1'b1, 1'b0, 1'b1);
      nv = b_valid ? 1 : 0; nd = 0;
      for (int j = 0; j < 128; j++) begin
         cyc(1'b0, 1'b0, 1'b1);
         if (b_valid) nv++;
         if (b_done)  nd++;
         if (b_valid && b_idx == 16'd41) chk("b_walk_41", 64'(b_vec), 64'(1));
         if (b_valid && b_idx == 16'd42) chk("b_walk_42", 64'(b_vec), 64'(2));
      end
      chk("b_walk_nvalid", 64'(nv), 64'(43));
      chk("b_walk_ndone",  64'(nd), 64'(1));

      // ---- B: LFSR stall, ready 1,0,0,1 ----
      b_mode = 2'd2; b_num = 16'd5; b_gap = 16'd0;
      cyc(1'b1, 1'b0, 1'b0);
      chk("b_lfsr_v0", 64'(b_vec), 64'(rep32(32'h1)));
      cyc(1'b0, 1'b0, 1'b1);
      chk("b_lfsr_v1", 64'(b_vec), 64'(rep32(32'h2)));
      cyc(1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0);
      chk("b_lfsr_stall", 64'(b_vec), 64'(rep32(32'h2)));
      cyc(1'b0, 1'b0, 1'b1);
      cyc(1'b0, 1'b1, 1'b1);  // stop together with an acceptance
      cyc(1'b0, 1'b0, 1'b0);

      // ---- B: reset in the middle of a run, start while busy ----
      b_mode = 2'd1; b_num = 16'd10; b_gap = 16'd1;
      cyc(1'b1, 1'b0, 1'b1);
      cyc(1'b0, 1'b0, 1'b1);
      cyc(1'b0, 1'b0, 1'b1);
      cyc(1'b0, 1'b0, 1'b1, 1'b0);
      chk("b_rst_busy", 64'(b_busy), 64'(0));
      chk("b_rst_vec",  64'(b_vec),  64'(0));
      cyc(1'b1, 1'b0, 1'b1);
      b_mode = 2'd3; b_num = 16'd2;
      cyc(1'b1, 1'b0, 1'b1);  // ignored, run keeps STAGGER/10
      for (int j = 0; j < 6; j++) cyc(1'b0, 1'b0, 1'b1);
      cyc(1'b0, 1'b1, 1'b0);

      // ---- B: LFSR 3 vectors with signature ----
      b_mode = 2'd2; b_num = 16'd3; b_gap = 16'd0;
      cyc(1'b1, 1'b0, 1'b0);
      for (int j = 0; j < 5; j++) cyc(1'b0, 1'b0, 1'b1);

      // ---- B: randomized ----
      for (int j = 0; j < 900; j++) begin
         b_mode = 2'($urandom_range(0, 3));
         b_num  = CB'($urandom_range(0, 9));
         b_gap  = CB'($urandom_range(0, 3));
         cyc($urandom_range(0, 7) == 0, $urandom_range(0, 29) == 0,
             $urandom_range(0, 3) != 0, $urandom_range(0, 199) != 0);
      end

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule
